bp_mem_cmd_arbiter: RTL and testbench

//  Shares one memory command/response port between two requesters (req 0 = icache UCE, req 1 = dcache/IO UCE).

---
 rtl/bp_mem_cmd_arbiter_if.sv | 62 ++++++
 rtl/bp_mem_cmd_arbiter.sv | 97 +++++++++
 tb/tb_bp_mem_cmd_arbiter.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/bp_mem_cmd_arbiter_if.sv
// Bundle of requester-side and memory-side command/response signals for bp_mem_cmd_arbiter.
// Signal direction suffixes are from the arbiter's point of view (slave modport).
interface bp_mem_cmd_arbiter_if #(
    parameter int unsigned msg_width_p       = 128,
    parameter int unsigned max_outstanding_p = 4
);
    localparam int unsigned cnt_w_lp = $clog2(max_outstanding_p + 1);

    // Requester side
    logic [2*msg_width_p-1:0] req_cmd_i;
    logic [1:0]               req_cmd_v_i;
    logic [1:0]               req_cmd_ready_o;
    logic [msg_width_p-1:0]   req_resp_o;
    logic [1:0]               req_resp_v_o;
    logic [1:0]               req_resp_yumi_i;

    // Memory side
    logic [msg_width_p-1:0]   mem_cmd_o;
    logic                     mem_cmd_v_o;
    logic                     mem_cmd_ready_i;
    logic [msg_width_p-1:0]   mem_resp_i;
    logic                     mem_resp_v_i;
    logic                     mem_resp_yumi_o;

    // Status
    logic [cnt_w_lp-1:0]      outstanding_o;
    logic                     error_o;

    modport slave (
        input  req_cmd_i,
        input  req_cmd_v_i,
        output req_cmd_ready_o,
        output req_resp_o,
        output req_resp_v_o,
        input  req_resp_yumi_i,
        output mem_cmd_o,
        output mem_cmd_v_o,
        input  mem_cmd_ready_i,
        input  mem_resp_i,
        input  mem_resp_v_i,
        output mem_resp_yumi_o,
        output outstanding_o,
        output error_o
    );

    modport master (
        output req_cmd_i,
        output req_cmd_v_i,
        input  req_cmd_ready_o,
        input  req_resp_o,
        input  req_resp_v_o,
        output req_resp_yumi_i,
        input  mem_cmd_o,
        input  mem_cmd_v_o,
        output mem_cmd_ready_i,
        output mem_resp_i,
        output mem_resp_v_i,
        input  mem_resp_yumi_o,
        input  outstanding_o,
        input  error_o
    );
endinterface

// File: rtl/bp_mem_cmd_arbiter.sv
// Two-requester round-robin command arbiter onto one memory port, with an in-order
// source-ID FIFO steering each memory response back to the requester that issued it.
module bp_mem_cmd_arbiter #(
    parameter int unsigned msg_width_p       = 128,
    parameter int unsigned max_outstanding_p = 4
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    bp_mem_cmd_arbiter_if.slave   bus
);
    localparam int unsigned ptr_w_lp = $clog2(max_outstanding_p);
    localparam int unsigned cnt_w_lp = $clog2(max_outstanding_p + 1);
    localparam logic [cnt_w_lp-1:0] full_cnt_lp = cnt_w_lp'(max_outstanding_p);

    // State
    logic                r_fifo [max_outstanding_p];
    logic [ptr_w_lp-1:0] r_wr_ptr;
    logic [ptr_w_lp-1:0] r_rd_ptr;
    logic [cnt_w_lp-1:0] r_count;
    logic                r_rr;
    logic                r_error;

    // Combinational
    logic       w_full;
    logic       w_empty;
    logic       w_gnt;
    logic       w_cmd_v;
    logic       w_cmd_ready;
    logic       w_fire;
    logic       w_head;
    logic       w_resp_v;
    logic [1:0] w_resp_v_vec;
    logic       w_pop;
    logic       w_err;

    // Command path
    always_comb begin
        w_full      = (r_count == full_cnt_lp);
        w_empty     = (r_count == '0);
        // Prefer r_rr; fall back to the other requester when r_rr is idle.
        w_gnt       = bus.req_cmd_v_i[r_rr] ? r_rr : ~r_rr;
        w_cmd_v     = reset_n_i & (|bus.req_cmd_v_i) & ~w_full;
        w_cmd_ready = reset_n_i & bus.mem_cmd_ready_i & ~w_full;
        w_fire      = w_cmd_v & bus.mem_cmd_ready_i;
    end

    assign bus.mem_cmd_v_o     = w_cmd_v;
    assign bus.mem_cmd_o       = w_gnt ? bus.req_cmd_i[2*msg_width_p-1:msg_width_p]
                                       : bus.req_cmd_i[msg_width_p-1:0];
    assign bus.req_cmd_ready_o = w_gnt ? {w_cmd_ready, 1'b0} : {1'b0, w_cmd_ready};

    // Response path
    always_comb begin
        w_head       = r_fifo[r_rd_ptr];
        w_resp_v     = reset_n_i & bus.mem_resp_v_i & ~w_empty;
        w_resp_v_vec = w_head ? {w_resp_v, 1'b0} : {1'b0, w_resp_v};
        w_pop        = bus.req_resp_yumi_i[w_head] & w_resp_v;
        // Orphan response, or a requester consuming something it was never offered.
        w_err        = reset_n_i & ((bus.mem_resp_v_i & w_empty)
                                    | (|(bus.req_resp_yumi_i & ~w_resp_v_vec)));
    end

    assign bus.req_resp_v_o    = w_resp_v_vec;
    assign bus.req_resp_o      = bus.mem_resp_i;
    assign bus.mem_resp_yumi_o = w_pop;
    assign bus.outstanding_o   = r_count;
    assign bus.error_o         = r_error;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < int'(max_outstanding_p); i++) begin
                r_fifo[i] <= 1'b0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_rr     <= 1'b0;
            r_error  <= 1'b0;
        end else begin
            if (w_fire) begin
                r_fifo[r_wr_ptr] <= w_gnt;
                r_wr_ptr         <= r_wr_ptr + ptr_w_lp'(1);
                r_rr             <= ~w_gnt;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + ptr_w_lp'(1);
            end
            unique case ({w_fire, w_pop})
                2'b10:   r_count <= r_count + cnt_w_lp'(1);
                2'b01:   r_count <= r_count - cnt_w_lp'(1);
                default: r_count <= r_count;
            endcase
            r_error <= r_error | w_err;
        end
    end

endmodule

// File: tb/tb_bp_mem_cmd_arbiter.sv
// Directed self-checking bench for bp_mem_cmd_arbiter: reset, round-robin grant,
// full blocking, stall, in-order response routing and sticky error.
module tb_bp_mem_cmd_arbiter;
    localparam int unsigned W = 16;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;

    bp_mem_cmd_arbiter_if #(.msg_width_p(W), .max_outstanding_p(4)) bus ();

    bp_mem_cmd_arbiter #(.msg_width_p(W), .max_outstanding_p(4)) dut (
        .clk_i     (clk),
        .reset_n_i (rst_n),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [W-1:0] CMD0 = 16'hA0A0;
    localparam logic [W-1:0] CMD1 = 16'hB1B1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issue one command with mem ready high; check grant, payload and resulting count.
    task automatic issue(input logic [1:0] v, input logic [1:0] exp_rdy,
                         input logic [W-1:0] exp_cmd, input int exp_cnt);
        bus.req_cmd_v_i     = v;
        bus.mem_cmd_ready_i = 1'b1;
        #1;
        check_eq("cmd_v", 32'(bus.mem_cmd_v_o), 32'd1);
        check_eq("cmd_rdy", 32'(bus.req_cmd_ready_o), 32'(exp_rdy));
        check_eq("cmd_data", 32'(bus.mem_cmd_o), 32'(exp_cmd));
        tick();
        check_eq("cnt_issue", 32'(bus.outstanding_o), 32'(exp_cnt));
        bus.req_cmd_v_i     = 2'b00;
        bus.mem_cmd_ready_i = 1'b0;
    endtask

    // Present a response; it must not pop without yumi, then pop on the matching yumi.
    task automatic resp(input logic [1:0] exp_v, input logic [W-1:0] data, input int cnt);
        bus.mem_resp_v_i    = 1'b1;
        bus.mem_resp_i      = data;
        bus.req_resp_yumi_i = 2'b00;
        #1;
        check_eq("resp_v", 32'(bus.req_resp_v_o), 32'(exp_v));
        check_eq("resp_noyumi", 32'(bus.mem_resp_yumi_o), 32'd0);
        tick();
        check_eq("cnt_hold", 32'(bus.outstanding_o), 32'(cnt));
        bus.req_resp_yumi_i = exp_v;
        #1;
        check_eq("resp_yumi", 32'(bus.mem_resp_yumi_o), 32'd1);
        check_eq("resp_data", 32'(bus.req_resp_o), 32'(data));
        tick();
        check_eq("cnt_pop", 32'(bus.outstanding_o), 32'(cnt - 1));
        bus.mem_resp_v_i    = 1'b0;
        bus.req_resp_yumi_i = 2'b00;
    endtask

    initial begin
        n_checks            = 0;
        n_pass              = 0;
        rst_n               = 1'b0;
        bus.req_cmd_i       = {CMD1, CMD0};
        bus.req_cmd_v_i     = 2'b11;
        bus.mem_cmd_ready_i = 1'b1;
        bus.mem_resp_i      = 16'h0;
        bus.mem_resp_v_i    = 1'b1;
        bus.req_resp_yumi_i = 2'b11;

        // 1: reset with everything asserted
        #1;
        for (int i = 0; i < 3; i++) begin
            check_eq("rst_outs", {26'd0, bus.mem_cmd_v_o, bus.req_cmd_ready_o,
                                  bus.req_resp_v_o, bus.mem_resp_yumi_o}, 32'd0);
            tick();
        end
        check_eq("rst_cnt", 32'(bus.outstanding_o), 32'd0);
        check_eq("rst_err", 32'(bus.error_o), 32'd0);
        bus.req_cmd_v_i     = 2'b00;
        bus.mem_cmd_ready_i = 1'b0;
        bus.mem_resp_v_i    = 1'b0;
        bus.req_resp_yumi_i = 2'b00;
        rst_n               = 1'b1;
        tick();

        // 2: both valid -> 0,1,0,1 then full
        issue(2'b11, 2'b01, CMD0, 1);
        issue(2'b11, 2'b10, CMD1, 2);
        issue(2'b11, 2'b01, CMD0, 3);
        issue(2'b11, 2'b10, CMD1, 4);
        bus.req_cmd_v_i     = 2'b11;
        bus.mem_cmd_ready_i = 1'b1;
        #1;
        check_eq("full_rdy", 32'(bus.req_cmd_ready_o), 32'd0);
        check_eq("full_v", 32'(bus.mem_cmd_v_o), 32'd0);

        // 5: pop while full -> no issue that cycle, issue next
        bus.mem_resp_v_i    = 1'b1;
        bus.mem_resp_i      = 16'h1234;
        bus.req_resp_yumi_i = 2'b01;
        #1;
        check_eq("fp_resp_v", 32'(bus.req_resp_v_o), 32'd1);
        check_eq("fp_yumi", 32'(bus.mem_resp_yumi_o), 32'd1);
        check_eq("fp_rdy", 32'(bus.req_cmd_ready_o), 32'd0);
        tick();
        check_eq("fp_cnt3", 32'(bus.outstanding_o), 32'd3);
        bus.mem_resp_v_i    = 1'b0;
        bus.req_resp_yumi_i = 2'b00;
        issue(2'b11, 2'b01, CMD0, 4);

        // Drain: FIFO order is 1,0,1,0
        resp(2'b10, 16'h5501, 4);
        resp(2'b01, 16'h5502, 3);
        resp(2'b10, 16'h5503, 2);
        resp(2'b01, 16'h5504, 1);

        // 3: issue 0,1,1 then route responses
        issue(2'b01, 2'b01, CMD0, 1);
        issue(2'b10, 2'b10, CMD1, 2);
        issue(2'b10, 2'b10, CMD1, 3);
        resp(2'b01, 16'h6601, 3);
        resp(2'b10, 16'h6602, 2);
        resp(2'b10, 16'h6603, 1);

        // 4: stall must not move rr; rr=1 before the stall
        issue(2'b01, 2'b01, CMD0, 1);
        bus.req_cmd_v_i     = 2'b01;
        bus.mem_cmd_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check_eq("stall_v", 32'(bus.mem_cmd_v_o), 32'd1);
            check_eq("stall_rdy", 32'(bus.req_cmd_ready_o), 32'd0);
            tick();
        end
        check_eq("stall_cnt", 32'(bus.outstanding_o), 32'd1);
        issue(2'b11, 2'b10, CMD1, 2);
        resp(2'b01, 16'h7701, 2);
        resp(2'b10, 16'h7702, 1);
        check_eq("no_err", 32'(bus.error_o), 32'd0);

        // 6: response with empty FIFO
        bus.mem_resp_v_i = 1'b1;
        #1;
        check_eq("orph_yumi", 32'(bus.mem_resp_yumi_o), 32'd0);
        check_eq("orph_v", 32'(bus.req_resp_v_o), 32'd0);
        tick();
        check_eq("orph_err", 32'(bus.error_o), 32'd1);
        bus.mem_resp_v_i = 1'b0;
        tick();
        tick();
        check_eq("err_sticky", 32'(bus.error_o), 32'd1);
        rst_n = 1'b0;
        tick();
        check_eq("err_clear", 32'(bus.error_o), 32'd0);
        rst_n = 1'b1;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
